// File: rtl/servo_pwm_frame_gen_pkg.sv
// Shared timing and width constants for the servo PWM channel, plus the
// pulse-width clamp shared with the modulation stage.
package servo_pwm_frame_gen_pkg;

    localparam int CLK_RATE      = 100_000_000;  // Hz
    localparam int FRAME_PERIOD  = 2_000_000;    // 20 ms frame in CLK cycles
    localparam int STATE_COUNT   = 24;           // frames per State sequence
    localparam int PULSE_MIN     = 100_000;      // 1.0 ms
    localparam int PULSE_MAX     = 200_000;      // 2.0 ms
    localparam int PULSE_NEUTRAL = 150_000;      // 1.5 ms safe idle

    localparam int PULSE_W = 21;
    localparam int STATE_W = 5;

    typedef logic [PULSE_W-1:0] pulse_t;
    typedef logic [STATE_W-1:0] state_t;

    // Registered output pair; PWM and FrameStart always update together.
    typedef struct packed {
        logic pwm;
        logic frame_start;
    } pwm_out_t;

    // Limit a requested high time to the legal servo window (unsigned compare).
    function automatic pulse_t clamp_pulse(pulse_t req, pulse_t lo, pulse_t hi);
        if (req < lo) begin
            return lo;
        end
        if (req > hi) begin
            return hi;
        end
        return req;
    endfunction

endpackage

// File: rtl/servo_pwm_frame_gen_if.sv
// Channel bus between the modulation stage (master) and the PWM frame
// generator (slave): enable and requested width go down, frame index and
// the physical waveform come back.
interface servo_pwm_frame_gen_if;
    import servo_pwm_frame_gen_pkg::*;

    logic   EN;
    pulse_t Pulse;
    state_t State;
    logic   PWM;
    logic   FrameStart;

    modport master (
        output EN,
        output Pulse,
        input  State,
        input  PWM,
        input  FrameStart
    );

    modport slave (
        input  EN,
        input  Pulse,
        output State,
        output PWM,
        output FrameStart
    );

endinterface

// File: rtl/servo_pwm_frame_gen_frame_counter.sv
// Frame sequencer: cycle counter wrapping every FRAME_PERIOD and a State
// index advancing once per frame, wrapping after STATE_COUNT frames.
// While disabled the counter parks at 0 and State holds.
module servo_pwm_frame_gen_frame_counter
    import servo_pwm_frame_gen_pkg::*;
#(
    parameter int FRAME_PERIOD = servo_pwm_frame_gen_pkg::FRAME_PERIOD,
    parameter int STATE_COUNT  = servo_pwm_frame_gen_pkg::STATE_COUNT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en_i,
    output pulse_t cnt_o,
    output state_t state_o,
    output logic   boundary_o
);

    localparam pulse_t CNT_LAST   = pulse_t'(FRAME_PERIOD - 1);
    localparam state_t STATE_LAST = state_t'(STATE_COUNT - 1);

    pulse_t cnt_q, cnt_d;
    state_t state_q, state_d;
    logic   boundary;

    // Last cycle of an enabled frame: everything frame-related turns over here.
    always_comb begin
        boundary = en_i && (cnt_q == CNT_LAST);
    end

    // Next counter and frame index.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d   = cnt_q;
        state_d = state_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (boundary) begin
            cnt_d   = '0;
            state_d = (state_q == STATE_LAST) ? '0 : state_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and frame-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign state_o    = state_q;
    assign boundary_o = boundary;

endmodule

// File: rtl/servo_pwm_frame_gen.sv
// Servo/ESC PWM frame generator: latches the clamped requested width at each
// frame boundary and emits a registered high pulse of that many cycles at
// the start of every frame, with a one-cycle FrameStart strobe.
module servo_pwm_frame_gen
    import servo_pwm_frame_gen_pkg::*;
#(
    parameter int CLK_RATE      = servo_pwm_frame_gen_pkg::CLK_RATE,
    parameter int FRAME_PERIOD  = servo_pwm_frame_gen_pkg::FRAME_PERIOD,
    parameter int STATE_COUNT   = servo_pwm_frame_gen_pkg::STATE_COUNT,
    parameter int PULSE_MIN     = servo_pwm_frame_gen_pkg::PULSE_MIN,
    parameter int PULSE_MAX     = servo_pwm_frame_gen_pkg::PULSE_MAX,
    parameter int PULSE_NEUTRAL = servo_pwm_frame_gen_pkg::PULSE_NEUTRAL
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    servo_pwm_frame_gen_if.slave   ch_if
);

    // Reject configurations the waveform cannot honour.
    if (CLK_RATE <= 0) begin : g_bad_clk_rate
        $error("servo_pwm_frame_gen: CLK_RATE must be positive");
    end
    if (PULSE_MIN > PULSE_MAX) begin : g_bad_pulse_range
        $error("servo_pwm_frame_gen: PULSE_MIN exceeds PULSE_MAX");
    end
    if (PULSE_NEUTRAL < PULSE_MIN || PULSE_NEUTRAL > PULSE_MAX) begin : g_bad_neutral
        $error("servo_pwm_frame_gen: PULSE_NEUTRAL outside legal window");
    end
    if (STATE_COUNT < 1 || STATE_COUNT > 32) begin : g_bad_state_count
        $error("servo_pwm_frame_gen: STATE_COUNT must be 1..32");
    end
    if (FRAME_PERIOD <= PULSE_MAX) begin : g_bad_frame_period
        $error("servo_pwm_frame_gen: FRAME_PERIOD must exceed PULSE_MAX");
    end
    if (FRAME_PERIOD > (1 << PULSE_W)) begin : g_bad_frame_width
        $error("servo_pwm_frame_gen: FRAME_PERIOD does not fit the counter");
    end

    localparam pulse_t P_MIN     = pulse_t'(PULSE_MIN);
    localparam pulse_t P_MAX     = pulse_t'(PULSE_MAX);
    localparam pulse_t P_NEUTRAL = pulse_t'(PULSE_NEUTRAL);

    logic     en;
    pulse_t   cnt;
    state_t   state;
    logic     boundary;
    pulse_t   width_q, width_d;
    pwm_out_t out_q, out_d;

    assign en = ch_if.EN;

    servo_pwm_frame_gen_frame_counter #(
        .FRAME_PERIOD (FRAME_PERIOD),
        .STATE_COUNT  (STATE_COUNT)
    ) u_frame_counter (
        .clk        (CLK),
        .rst_n      (RST_N),
        .en_i       (en),
        .cnt_o      (cnt),
        .state_o    (state),
        .boundary_o (boundary)
    );

    // Width for the next frame: neutral while idle, else the clamped request
    // sampled only on the boundary edge so mid-frame changes wait a frame.
    always_comb begin
        width_d = width_q;
        if (!en) begin
            width_d = P_NEUTRAL;
        end else if (boundary) begin
            width_d = clamp_pulse(ch_if.Pulse, P_MIN, P_MAX);
        end
    end

    // Waveform decode from the current counter; lags cnt by one cycle.
    always_comb begin
        out_d.pwm         = en && (cnt < width_q);
        out_d.frame_start = en && (cnt == '0);
    end

    // Width register and registered PWM outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            width_q <= P_NEUTRAL;
            out_q   <= '0;
        end else begin
            width_q <= width_d;
            out_q   <= out_d;
        end
    end

    assign ch_if.State      = state;
    assign ch_if.PWM        = out_q.pwm;
    assign ch_if.FrameStart = out_q.frame_start;

endmodule

// File: tb/tb_servo_pwm_frame_gen.sv
// Bench for servo_pwm_frame_gen with shortened timing. The reference tracks
// position in frame as (enabled edges since enable) mod FRAME_PERIOD and the
// width of each frame as the clamp of Pulse seen on the previous frame's
// last cycle; outputs are compared every cycle, plus per-frame high counts.
module tb_servo_pwm_frame_gen;
    import servo_pwm_frame_gen_pkg::*;

    localparam int FP   = 100;
    localparam int PMIN = 10;
    localparam int PNEU = 15;
    localparam int PMAX = 20;
    localparam int SC   = 24;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;

    servo_pwm_frame_gen_if ch_if ();

    servo_pwm_frame_gen #(
        .CLK_RATE      (100_000_000),
        .FRAME_PERIOD  (FP),
        .STATE_COUNT   (SC),
        .PULSE_MIN     (PMIN),
        .PULSE_MAX     (PMAX),
        .PULSE_NEUTRAL (PNEU)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .ch_if (ch_if)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference state
    int   m_edges = 0;      // enabled edges since last enable/reset
    int   m_width = PNEU;   // width of the frame in progress
    int   m_state = 0;
    logic m_pwm   = 1'b0;
    logic m_fs    = 1'b0;

    function automatic int clamp_ref(int p);
        if (p < PMIN) return PMIN;
        if (p > PMAX) return PMAX;
        return p;
    endfunction

    function automatic int rand_pulse();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, PMIN - 1));
            1:       return int'($urandom_range(PMIN, PMAX));
            2:       return int'($urandom_range(PMAX + 1, 2097151));
            default: return 2097151;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_edges = 0;
        m_width = PNEU;
        m_state = 0;
        m_pwm   = 1'b0;
        m_fs    = 1'b0;
    endtask

    // One clock: advance the reference on the edge, compare at the negedge.
    task automatic step();
        int pos;
        @(posedge CLK);
        if (!RST_N) begin
            model_reset();
        end else if (ch_if.EN) begin
            pos   = m_edges % FP;
            m_pwm = (pos < m_width);
            m_fs  = (pos == 0);
            if (pos == FP - 1) begin
                m_width = clamp_ref(int'(ch_if.Pulse));
                m_state = (m_state + 1) % SC;
            end
            m_edges++;
        end else begin
            m_pwm   = 1'b0;
            m_fs    = 1'b0;
            m_edges = 0;
            m_width = PNEU;
        end
        @(negedge CLK);
        check("pwm",   32'(ch_if.PWM),        32'(m_pwm));
        check("fs",    32'(ch_if.FrameStart), 32'(m_fs));
        check("state", 32'(ch_if.State),      32'(m_state));
    endtask

    task automatic set_pulse(int v);
        ch_if.Pulse = PULSE_W'(v);
    endtask

    // Step until the frame counter (per reference) reads pos.
    task automatic run_until(int pos);
        for (int g = 0; g < 2 * FP; g++) begin
            if ((m_edges % FP) == pos) break;
            step();
        end
    endtask

    // Run one whole frame from its first edge and count PWM high cycles;
    // optionally change Pulse when the counter reaches chg_at.
    task automatic measure_frame(int exp_hi, int chg_at, int chg_val);
        int hi;
        hi = 0;
        for (int i = 0; i < FP; i++) begin
            if (i == chg_at) set_pulse(chg_val);
            step();
            if (ch_if.PWM === 1'b1) hi++;
        end
        check("frame_hi", 32'(hi), 32'(exp_hi));
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ch_if.EN = 1'b1;
        set_pulse(12);
        #1 RST_N = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        check("rst_pwm",   32'(ch_if.PWM),        32'd0);
        check("rst_fs",    32'(ch_if.FrameStart), 32'd0);
        check("rst_state", 32'(ch_if.State),      32'd0);
        RST_N = 1'b1;

        // Neutral first frame, then requested width; range clamping.
        measure_frame(PNEU, -1, 0);
        measure_frame(12, -1, 0);
        set_pulse(5);
        measure_frame(12, -1, 0);
        set_pulse(2097151);
        measure_frame(PMIN, -1, 0);
        set_pulse(12);
        measure_frame(PMAX, -1, 0);
        check("state_after5", 32'(ch_if.State), 32'd5);

        // Mid-frame Pulse change only takes effect next frame.
        measure_frame(12, 50, 18);
        set_pulse(12);
        measure_frame(18, -1, 0);

        // Run on to the State wrap.
        for (int f = 7; f < SC; f++) measure_frame(12, -1, 0);
        check("state_wrap0", 32'(ch_if.State), 32'd0);
        measure_frame(12, -1, 0);
        check("state_wrap1", 32'(ch_if.State), 32'd1);

        // Disable during the 5th high cycle.
        run_until(5);
        check("pwm_before_dis", 32'(ch_if.PWM), 32'd1);
        ch_if.EN = 1'b0;
        repeat (30) step();
        check("state_held", 32'(ch_if.State), 32'd1);
        ch_if.EN = 1'b1;
        measure_frame(PNEU, -1, 0);
        measure_frame(12, -1, 0);

        // Asynchronous reset mid-pulse.
        run_until(5);
        check("pwm_before_rst", 32'(ch_if.PWM), 32'd1);
        RST_N = 1'b0;
        model_reset();
        #1;
        check("async_rst_pwm",   32'(ch_if.PWM),        32'd0);
        check("async_rst_state", 32'(ch_if.State),      32'd0);
        check("async_rst_fs",    32'(ch_if.FrameStart), 32'd0);
        repeat (3) step();
        RST_N = 1'b1;
        measure_frame(PNEU, -1, 0);
        measure_frame(12, -1, 0);

        // Random Pulse changes and enable toggling.
        for (int c = 0; c < 20 * FP; c++) begin
            if ($urandom_range(0, 39) == 0) set_pulse(rand_pulse());
            if (ch_if.EN && $urandom_range(0, 299) == 0) begin
                ch_if.EN = 1'b0;
            end else if (!ch_if.EN && $urandom_range(0, 9) == 0) begin
                ch_if.EN = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
